man_anim_sequencer: RTL
=======================

Name: man_anim_sequencer

Overview:
- Drives the 4-bit `man_state` animation index consumed by the VGA displayer and the LED decoder in the LAB12 display path.
- Advances the index once every N video frames, only on the frame boundary pulse, so a frame is never drawn with a mid-frame state change.
- Supports run/pause, single-step, direction, and loop or ping-pong sequencing, all selected from switch-derived inputs.
- Runs in the 25 MHz pixel clock domain, alongside the VGA timing logic.

Parameters:
- NUM_STATES, 8, number of animation states; valid indices 1..NUM_STATES; must be 2..15.
- SPD_W, 3, width of the speed field; the advance period is speed+1 frames.

Ports:
- clk, input, 1, 25 MHz pixel clock.
- rst, input, 1, reset; synchronous, active-high.
- frame_tick, input, 1, one-cycle pulse at start of vertical blanking, from the VGA timing block.
- run, input, 1, 1 = free-running animation, 0 = paused.
- dir, input, 1, loop mode only: 0 = ascending, 1 = descending.
- pingpong, input, 1, 1 = bounce between 1 and NUM_STATES; 0 = wrap-around loop.
- speed, input, SPD_W, advance once every speed+1 frames.
- step, input, 1, one-cycle pulse (debounced button) requesting a single advance while paused.
- man_state, output, 4, current animation index; 0 = blank.
- state_changed, output, 1, one-cycle pulse coincident with each `man_state` update.

Behaviour:
- All flops reset synchronously when rst=1 at a clk edge.
  - Reset values: man_state=0, state_changed=0, FSM=S_BLANK, frm_cnt=0, step_pend=0, pp_dir=0 (ascending).
- FSM states: S_BLANK, S_RUN, S_PAUSE.
- S_BLANK:
  - Waits for frame_tick.
  - On frame_tick: man_state<=1, state_changed pulses, frm_cnt<=0.
  - Next state is S_RUN if run=1 that cycle, else S_PAUSE.
  - step is ignored in S_BLANK.
- S_RUN, evaluated only on frame_tick:
  - If run=0: go to S_PAUSE, no advance, frm_cnt held.
  - Else if frm_cnt >= speed: advance, frm_cnt<=0.
  - Else: frm_cnt<=frm_cnt+1.
  - The >= compare makes a mid-count reduction of speed take effect at the very next tick.
  - step pulses are ignored in S_RUN and do not set step_pend.
- S_PAUSE:
  - A step pulse sets step_pend; multiple steps between ticks collapse into one advance.
  - On frame_tick with run=1: go to S_RUN, frm_cnt<=0, step_pend<=0, no advance on this tick.
  - On frame_tick with run=0: if step_pend or step in the same cycle, advance once and clear step_pend; otherwise hold.
- Advance rule, loop mode (pingpong=0):
  - dir=0: next = cur+1, wrapping NUM_STATES->1.
  - dir=1: next = cur-1, wrapping 1->NUM_STATES.
- Advance rule, ping-pong mode (pingpong=1):
  - dir is ignored; the internal pp_dir selects the direction.
  - Ascending at NUM_STATES: pp_dir<=1, next = NUM_STATES-1.
  - Descending at 1: pp_dir<=0, next = 2.
  - Otherwise next = cur+1 if pp_dir=0, else cur-1.
  - pp_dir holds its value while pingpong=0.
- Output timing and value range:
  - man_state changes only on the clk edge that samples frame_tick=1; it is a registered output.
  - state_changed is high for exactly that one following cycle; it is not asserted when the value is held.
  - man_state never holds a value outside 0..NUM_STATES; 0 occurs only after reset before the first tick.
- Latency: frame_tick sampled at edge k gives the new man_state valid after edge k.
- Reset mid-operation: the next edge returns to S_BLANK/0 regardless of pending steps or counts.
- frame_tick held high for multiple cycles is illegal; each high cycle counts as a tick (not filtered).

Test Plan:
- Reset, run=1, speed=0, dir=0, pingpong=0, 10 frame_ticks → man_state sequence 1,2,3,4,5,6,7,8,1,2; one state_changed pulse per tick; man_state=0 before the first tick.
- run=1, speed=2, 7 ticks after blank exit → man_state 1,1,1,2,2,2,3 (advance on every third tick); change speed 2→0 with frm_cnt=2 → advance on the next tick.
- pingpong=1, speed=0, starting from man_state=7 ascending, 6 ticks → 8,7,6,5,4,3; then from 2 descending → 1,2.
- Pause at man_state=4: three step pulses before the next tick → exactly one advance to 5 at that tick; a tick with no step → stays 5, no state_changed.
- Step coincident with frame_tick in S_PAUSE → advance on that same tick. Setting run=1 at a tick → no advance that tick, counting restarts from 0.
- Assert rst mid-run with man_state=6 and step_pend=1 → the next edge gives man_state=0, state_changed=0; the first tick after release gives 1.

Source files
------------

// File: rtl/man_anim_sequencer.sv
// rtl/man_anim_sequencer.sv - frame-synchronous animation index sequencer
module man_anim_sequencer #(
   parameter int NUM_STATES = 8,
   parameter int SPD_W      = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_tick,
   input  logic             run,
   input  logic             dir,
   input  logic             pingpong,
   input  logic [SPD_W-1:0] speed,
   input  logic             step,
   output logic [3:0]       man_state,
   output logic             state_changed
);

   typedef enum logic [1:0] {S_BLANK, S_RUN, S_PAUSE} state_t;

   localparam logic [3:0] L_LAST = NUM_STATES[3:0];
   localparam logic [3:0] L_PREV = L_LAST - 4'd1;

   state_t           r_state;
   state_t           w_next_state;
   logic [SPD_W-1:0] r_frm_cnt;
   logic [SPD_W-1:0] w_frm_cnt_nxt;
   logic             r_step_pend;
   logic             w_step_pend_nxt;
   logic             r_pp_dir;
   logic             w_pp_dir_nxt;
   logic [3:0]       r_man_state;
   logic             r_changed;
   logic             w_adv;
   logic             w_load_one;
   logic [3:0]       w_adv_val;

   // Next index for one advance step, plus the bounce direction update
   always_comb begin
      w_adv_val    = r_man_state;
      w_pp_dir_nxt = r_pp_dir;
      if (pingpong) begin
         if (!r_pp_dir) begin
            if (r_man_state == L_LAST) begin
               w_pp_dir_nxt = 1'b1;
               w_adv_val    = L_PREV;
            end else begin
               w_adv_val = r_man_state + 4'd1;
            end
         end else begin
            if (r_man_state == 4'd1) begin
               w_pp_dir_nxt = 1'b0;
               w_adv_val    = 4'd2;
            end else begin
               w_adv_val = r_man_state - 4'd1;
            end
         end
      end else if (!dir) begin
         w_adv_val = (r_man_state == L_LAST) ? 4'd1 : r_man_state + 4'd1;
      end else begin
         w_adv_val = (r_man_state == 4'd1) ? L_LAST : r_man_state - 4'd1;
      end
   end

   // Sequencer FSM: decides on each frame tick whether to load, advance or hold
   always_comb begin
      w_next_state    = r_state;
      w_frm_cnt_nxt   = r_frm_cnt;
      w_step_pend_nxt = r_step_pend;
      w_adv           = 1'b0;
      w_load_one      = 1'b0;
      case (r_state)
         S_BLANK: begin
            if (frame_tick) begin
               w_load_one    = 1'b1;
               w_frm_cnt_nxt = '0;
               w_next_state  = run ? S_RUN : S_PAUSE;
            end
         end
         S_RUN: begin
            if (frame_tick) begin
               if (!run) begin
                  w_next_state = S_PAUSE;
               end else if (r_frm_cnt >= speed) begin
                  // >= so a speed reduction mid-count lands on the next tick
                  w_adv         = 1'b1;
                  w_frm_cnt_nxt = '0;
               end else begin
                  w_frm_cnt_nxt = r_frm_cnt + 1'b1;
               end
            end
         end
         S_PAUSE: begin
            if (frame_tick) begin
               if (run) begin
                  w_next_state    = S_RUN;
                  w_frm_cnt_nxt   = '0;
                  w_step_pend_nxt = 1'b0;
               end else if (r_step_pend || step) begin
                  w_adv           = 1'b1;
                  w_step_pend_nxt = 1'b0;
               end
            end else if (step) begin
               w_step_pend_nxt = 1'b1;
            end
         end
         default: w_next_state = S_BLANK;
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_BLANK;
         r_frm_cnt   <= '0;
         r_step_pend <= 1'b0;
         r_pp_dir    <= 1'b0;
         r_man_state <= 4'd0;
         r_changed   <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_frm_cnt   <= w_frm_cnt_nxt;
         r_step_pend <= w_step_pend_nxt;
         r_changed   <= w_adv | w_load_one;
         if (w_load_one) begin
            r_man_state <= 4'd1;
         end else if (w_adv) begin
            r_man_state <= w_adv_val;
            r_pp_dir    <= w_pp_dir_nxt;
         end
      end
   end

   assign man_state     = r_man_state;
   assign state_changed = r_changed;

endmodule
